// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory responder.
package lc3_mem_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_DONE
  } state_e;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } mem_op_e;

  // Zero the byte lanes whose active-low select is deasserted.
  function automatic logic [WORD_W-1:0] lane_mask(input logic [WORD_W-1:0] word,
                                                  input logic ub_n,
                                                  input logic lb_n);
    return {(ub_n ? 8'h00 : word[15:8]), (lb_n ? 8'h00 : word[7:0])};
  endfunction

endpackage

// File: rtl/lc3_mem_responder_if.sv
// LC-3 CPU memory bus: active-low strobes, address and data, plus responder status.
interface lc3_mem_responder_if;
  import lc3_mem_pkg::*;

  logic [WORD_W-1:0] A;
  logic              CE;
  logic              OE;
  logic              WE;
  logic              UB;
  logic              LB;
  logic [WORD_W-1:0] Data_in;
  logic [WORD_W-1:0] Data_out;
  logic              Data_drive;
  logic              R;
  logic              Busy;
  logic              Err;

  modport master (
    output A, CE, OE, WE, UB, LB, Data_in,
    input  Data_out, Data_drive, R, Busy, Err
  );

  modport slave (
    input  A, CE, OE, WE, UB, LB, Data_in,
    output Data_out, Data_drive, R, Busy, Err
  );
endinterface

// File: rtl/lc3_mem_array.sv
// Single-port synchronous word RAM with byte enables and one-cycle read latency.
module lc3_mem_array
  import lc3_mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [1:0]        be,
  input  logic              we,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  // Byte-laned write and registered read (old data on a same-cycle write).
  // NOTE: the array has no reset; the responder's post-reset fill initialises it,
  // and non-blocking assignments keep read-before-write ordering well defined.
  always_ff @(posedge clk) begin
    if (we) begin
      if (be[0]) mem[addr][7:0]  <= wdata[7:0];
      if (be[1]) mem[addr][15:8] <= wdata[15:8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/lc3_mem_responder.sv
// Memory-side responder for the LC-3 bus: post-reset fill, wait states,
// byte-laned reads/writes and a one-cycle ready pulse per access.
module lc3_mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int                ADDR_W      = 10,
  parameter int                WAIT_STATES = 2,
  parameter logic [WORD_W-1:0] INIT_VAL    = 16'h0000
) (
  input  logic                Clk,
  input  logic                Reset,
  lc3_mem_responder_if.slave  bus
);

  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_e            state_q,     state_d;
  mem_op_e           op_q,        op_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [3:0]        cnt_q,       cnt_d;
  logic              ub_q,        ub_d;
  logic              lb_q,        lb_d;
  logic [WORD_W-1:0] wdata_q,     wdata_d;
  logic [WORD_W-1:0] hold_q,      hold_d;
  logic              err_q,       err_d;

  logic [ADDR_W-1:0] ram_addr;
  logic [WORD_W-1:0] ram_wdata;
  logic [WORD_W-1:0] ram_rdata;
  logic [WORD_W-1:0] read_word;
  logic [1:0]        ram_be;
  logic              ram_we;
  logic              start;
  logic              abort;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^bus.A[WORD_W-1:ADDR_W];
  assign start     = ~bus.CE & (~bus.OE | ~bus.WE);
  assign abort     = bus.CE | (bus.OE & bus.WE);
  assign read_word = lane_mask(ram_rdata, ub_q, lb_q);

  lc3_mem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (Clk),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .be    (ram_be),
    .we    (ram_we),
    .rdata (ram_rdata)
  );

  // State and request registers; reset abandons any access and restarts the fill.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_INIT;
      op_q        <= OP_READ;
      fill_addr_q <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      ub_q        <= 1'b1;
      lb_q        <= 1'b1;
      wdata_q     <= '0;
      hold_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      fill_addr_q <= fill_addr_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      ub_q        <= ub_d;
      lb_q        <= lb_d;
      wdata_q     <= wdata_d;
      hold_q      <= hold_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic: fill, access start/latch, wait countdown, response, release.
  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    fill_addr_d = fill_addr_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    ub_d        = ub_q;
    lb_d        = lb_q;
    wdata_d     = wdata_q;
    hold_d      = hold_q;
    err_d       = 1'b0;
    case (state_q)
      ST_INIT: begin
        fill_addr_d = fill_addr_q + 1'b1;
        if (&fill_addr_q) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (start) begin
          addr_d  = bus.A[ADDR_W-1:0];
          ub_d    = bus.UB;
          lb_d    = bus.LB;
          wdata_d = bus.Data_in;
          op_d    = bus.WE ? OP_READ : OP_WRITE;
          err_d   = ~bus.OE & ~bus.WE;
          if (WAIT_STATES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (abort)               state_d = ST_IDLE;
        else if (cnt_q == 4'd0)  state_d = ST_RESP;
        else                     cnt_d   = cnt_q - 1'b1;
      end
      ST_RESP: begin
        hold_d  = read_word;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (abort) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // RAM port steering: fill writes, live address in IDLE so a zero-wait read is
  // issued on the start edge, latched address otherwise; writes land in RESP.
  always_comb begin
    ram_addr  = addr_q;
    ram_we    = 1'b0;
    ram_be    = 2'b11;
    ram_wdata = INIT_VAL;
    case (state_q)
      ST_INIT: begin
        ram_addr = fill_addr_q;
        ram_we   = 1'b1;
      end
      ST_IDLE: ram_addr = bus.A[ADDR_W-1:0];
      ST_RESP: begin
        if (op_q == OP_WRITE) begin
          ram_we    = 1'b1;
          ram_be    = {~ub_q, ~lb_q};
          ram_wdata = wdata_q;
        end
      end
      default: ;
    endcase
  end

  // Bus-facing outputs decoded from state so reset clears them immediately.
  always_comb begin
    bus.Data_out   = '0;
    bus.Data_drive = 1'b0;
    if (op_q == OP_READ) begin
      if (state_q == ST_RESP) begin
        bus.Data_out   = read_word;
        bus.Data_drive = 1'b1;
      end else if (state_q == ST_DONE) begin
        bus.Data_out   = hold_q;
        bus.Data_drive = ~bus.CE & ~bus.OE;
      end
    end
  end

  assign bus.R    = (state_q == ST_RESP);
  assign bus.Busy = (state_q == ST_INIT);
  assign bus.Err  = err_q;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Scoreboard bench for lc3_mem_responder (ADDR_W=10, WAIT_STATES=2, INIT_VAL=0).
module tb_lc3_mem_responder;
  import lc3_mem_pkg::*;

  localparam int WS = 2;

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;
  logic [15:0] exp_q[$];

  lc3_mem_responder_if bus ();

  lc3_mem_responder #(
    .ADDR_W      (10),
    .WAIT_STATES (WS),
    .INIT_VAL    (16'h0000)
  ) dut (
    .Clk   (clk),
    .Reset (reset_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_bus();
    bus.CE = 1'b1; bus.OE = 1'b1; bus.WE = 1'b1;
    bus.UB = 1'b1; bus.LB = 1'b1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Waits for the post-reset fill to finish and checks its length.
  task automatic wait_fill(input string name);
    int n;
    n = 0;
    while (bus.Busy === 1'b1 && n < 2000) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n !== 1024) begin
      miscompares++;
      $display("FAIL %s: busy cycles actual=%0d required=1024", name, n);
    end
  endtask

  // One complete access from IDLE; reads push the expected word to the scoreboard
  // and pop it when R is observed. Called on a negedge.
  task automatic access(input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                        input bit ub, input bit lb, input logic [15:0] exp, input string name);
    int lat;
    bit got;
    logic [15:0] e;
    bus.A = addr; bus.Data_in = wd; bus.UB = ub; bus.LB = lb; bus.CE = 1'b0;
    if (wr) bus.WE = 1'b0; else bus.OE = 1'b0;
    if (!wr) exp_q.push_back(exp);
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (bus.R === 1'b1) got = 1'b1;
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL %s: R timeout actual=none required=pulse", name);
      if (!wr) void'(exp_q.pop_front());
    end else begin
      vectors++;
      if (lat !== WS + 1) begin
        miscompares++;
        $display("FAIL %s: latency actual=%0d required=%0d", name, lat, WS + 1);
      end
      vectors++;
      if (bus.Data_drive !== !wr) begin
        miscompares++;
        $display("FAIL %s: Data_drive actual=%b required=%b", name, bus.Data_drive, !wr);
      end
      if (!wr) begin
        e = exp_q.pop_front();
        vectors++;
        if (bus.Data_out !== e) begin
          miscompares++;
          $display("FAIL %s: Data_out actual=%h required=%h", name, bus.Data_out, e);
        end
      end
    end
    idle_bus();
    cycles(2);
    vectors++;
    if (bus.R !== 1'b0 || bus.Data_drive !== 1'b0 || bus.Data_out !== 16'h0000) begin
      miscompares++;
      $display("FAIL %s: idle after access actual R=%b drv=%b dout=%h required 0/0/0000",
               name, bus.R, bus.Data_drive, bus.Data_out);
    end
  endtask

  task automatic test_reset();
    idle_bus();
    bus.A = '0; bus.Data_in = '0;
    reset_n = 1'b0;
    #12;
    vectors++;
    if (bus.Busy !== 1'b1 || bus.R !== 1'b0 || bus.Err !== 1'b0 ||
        bus.Data_drive !== 1'b0 || bus.Data_out !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_outputs: busy=%b r=%b err=%b drv=%b dout=%h required 1/0/0/0/0000",
               bus.Busy, bus.R, bus.Err, bus.Data_drive, bus.Data_out);
    end
    @(negedge clk);
    reset_n = 1'b1;
    wait_fill("reset_fill");
    access(0, 16'h0000, 16'h0, 0, 0, 16'h0000, "init_read_0000");
    access(0, 16'h03FF, 16'h0, 0, 0, 16'h0000, "init_read_03ff");
  endtask

  task automatic test_write_read();
    access(1, 16'h0012, 16'hBEEF, 0, 0, 16'h0, "write_beef");
    access(0, 16'h0012, 16'h0,    0, 0, 16'hBEEF, "read_beef");
  endtask

  task automatic test_byte_lanes();
    access(1, 16'h0012, 16'h1234, 1, 0, 16'h0, "write_low_lane");
    access(0, 16'h0012, 16'h0, 0, 0, 16'hBE34, "read_be34");
    access(0, 16'h0012, 16'h0, 0, 1, 16'hBE00, "read_upper_only");
    access(0, 16'h0012, 16'h0, 1, 1, 16'h0000, "read_no_lanes");
    access(1, 16'h0012, 16'hFFFF, 1, 1, 16'h0, "write_no_lanes");
    access(0, 16'h0412, 16'h0, 0, 0, 16'hBE34, "read_alias_0412");
  endtask

  task automatic test_abort();
    int rcount;
    bus.A = 16'h0003; bus.Data_in = 16'h5555; bus.UB = 1'b0; bus.LB = 1'b0;
    bus.CE = 1'b0; bus.WE = 1'b0;
    cycles(1);
    bus.CE = 1'b1; bus.WE = 1'b1;
    rcount = 0;
    for (int i = 0; i < 6; i++) begin
      cycles(1);
      if (bus.R === 1'b1) rcount++;
    end
    vectors++;
    if (rcount !== 0) begin
      miscompares++;
      $display("FAIL abort_no_r: R pulses actual=%0d required=0", rcount);
    end
    access(0, 16'h0003, 16'h0, 0, 0, 16'h0000, "abort_mem_unchanged");
  endtask

  task automatic test_held_strobes();
    int rcount;
    int ecount;
    logic e1;
    bus.A = 16'h0012; bus.UB = 1'b0; bus.LB = 1'b0; bus.CE = 1'b0; bus.OE = 1'b0;
    rcount = 0;
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      if (bus.R === 1'b1) rcount++;
    end
    vectors++;
    if (rcount !== 1) begin
      miscompares++;
      $display("FAIL held_one_r: R pulses actual=%0d required=1", rcount);
    end
    vectors++;
    if (bus.Data_drive !== 1'b1 || bus.Data_out !== 16'hBE34) begin
      miscompares++;
      $display("FAIL held_data: drv=%b dout=%h required 1/be34", bus.Data_drive, bus.Data_out);
    end
    bus.OE = 1'b1;
    cycles(1);
    bus.OE = 1'b0;
    rcount = 0;
    for (int i = 0; i < 6; i++) begin
      cycles(1);
      if (bus.R === 1'b1) rcount++;
    end
    vectors++;
    if (rcount !== 1) begin
      miscompares++;
      $display("FAIL retrigger_r: R pulses actual=%0d required=1", rcount);
    end
    idle_bus();
    cycles(2);
    // OE and WE low together: a write plus a single Err pulse.
    bus.A = 16'h0020; bus.Data_in = 16'h0F0F; bus.UB = 1'b0; bus.LB = 1'b0;
    bus.CE = 1'b0; bus.OE = 1'b0; bus.WE = 1'b0;
    rcount = 0; ecount = 0; e1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycles(1);
      if (i == 0) e1 = bus.Err;
      if (bus.Err === 1'b1) ecount++;
      if (bus.R === 1'b1) rcount++;
    end
    vectors++;
    if (e1 !== 1'b1 || ecount !== 1) begin
      miscompares++;
      $display("FAIL err_pulse: first=%b count=%0d required 1/1", e1, ecount);
    end
    vectors++;
    if (rcount !== 1) begin
      miscompares++;
      $display("FAIL err_r: R pulses actual=%0d required=1", rcount);
    end
    idle_bus();
    cycles(2);
    access(0, 16'h0020, 16'h0, 0, 0, 16'h0F0F, "err_write_landed");
  endtask

  task automatic test_reset_mid_access();
    bus.A = 16'h0030; bus.Data_in = 16'hAAAA; bus.UB = 1'b0; bus.LB = 1'b0;
    bus.CE = 1'b0; bus.OE = 1'b0; bus.WE = 1'b0;
    cycles(1);
    vectors++;
    if (bus.Err !== 1'b1 || bus.Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL pre_reset_state: err=%b busy=%b required 1/0", bus.Err, bus.Busy);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if (bus.Busy !== 1'b1 || bus.R !== 1'b0 || bus.Err !== 1'b0 ||
        bus.Data_drive !== 1'b0 || bus.Data_out !== 16'h0000) begin
      miscompares++;
      $display("FAIL midreset_outputs: busy=%b r=%b err=%b drv=%b dout=%h required 1/0/0/0/0000",
               bus.Busy, bus.R, bus.Err, bus.Data_drive, bus.Data_out);
    end
    idle_bus();
    @(negedge clk);
    reset_n = 1'b1;
    wait_fill("refill");
    access(0, 16'h0012, 16'h0, 0, 0, 16'h0000, "refill_0012");
    access(0, 16'h0030, 16'h0, 0, 0, 16'h0000, "refill_0030");
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_abort();
    test_held_strobes();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
